// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
//   Bundle of signals between the multi-cycle RV32I sequencing FSM and its
//   datapath / shared memory.
//
//   master modport : the control FSM (consumes IR fields, ALU zero, mem_ready;
//                    drives every strobe, mux select, trap, state, instret)
//   slave modport  : the datapath / memory side (the mirror image)
//
//   Fields:
//     opcode, funct3 : IR[6:0] and IR[14:12], stable from DECODE onward
//     zero           : ALU zero flag
//     mem_ready      : memory completes the current access this cycle
//     pc_write, ir_write, addr_src, mem_read, mem_write, reg_write : strobes
//     alu_src_a, alu_src_b, alu_op, result_src : mux / decoder selects
//     trap           : sticky illegal-instruction flag
//     state          : current FSM state (debug)
//     instret        : retired-instruction count
// -----------------------------------------------------------------------------
interface multicycle_control_if #(
   parameter int INSTRET_W = 32
);
   logic [6:0]           opcode;
   logic [2:0]           funct3;
   logic                 zero;
   logic                 mem_ready;

   logic                 pc_write;
   logic                 ir_write;
   logic                 addr_src;
   logic                 mem_read;
   logic                 mem_write;
   logic [1:0]           alu_src_a;
   logic [1:0]           alu_src_b;
   logic [1:0]           alu_op;
   logic [1:0]           result_src;
   logic                 reg_write;
   logic                 trap;
   logic [3:0]           state;
   logic [INSTRET_W-1:0] instret;

   modport master (
      input  opcode, funct3, zero, mem_ready,
      output pc_write, ir_write, addr_src, mem_read, mem_write,
             alu_src_a, alu_src_b, alu_op, result_src, reg_write,
             trap, state, instret
   );

   modport slave (
      output opcode, funct3, zero, mem_ready,
      input  pc_write, ir_write, addr_src, mem_read, mem_write,
             alu_src_a, alu_src_b, alu_op, result_src, reg_write,
             trap, state, instret
   );
endinterface

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Main sequencing FSM of the multi-cycle RV32I core. Walks each instruction
//   through fetch, decode, execute, memory and writeback, drives the ALU
//   operand muxes and alu_op, handshakes with the shared instruction/data
//   memory via mem_ready, counts retired instructions and parks in a sticky
//   TRAP state on unsupported opcodes.
//
//   Ports:
//     clk    : single clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : multicycle_control_if.master (see interface for field list)
//
//   Outputs are Moore-decoded from the registered state, except ir_write and
//   pc_write in FETCH (qualified by mem_ready) and pc_write in BRANCH
//   (qualified by zero).
// -----------------------------------------------------------------------------
module multicycle_control #(
   parameter int INSTRET_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   multicycle_control_if.master  bus
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_EXEC_R    = 4'd7,
      S_EXEC_I    = 4'd8,
      S_ALU_WB    = 4'd9,
      S_BRANCH    = 4'd10,
      S_TRAP      = 4'd11
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [2:0] F3_ADDI   = 3'b000;
   localparam logic [2:0] F3_BEQ    = 3'b000;

   // Mux select encodings
   localparam logic [1:0] SRC_A_PC    = 2'b00;
   localparam logic [1:0] SRC_A_OLDPC = 2'b01;
   localparam logic [1:0] SRC_A_REGA  = 2'b10;
   localparam logic [1:0] SRC_B_REGB  = 2'b00;
   localparam logic [1:0] SRC_B_FOUR  = 2'b01;
   localparam logic [1:0] SRC_B_IMM   = 2'b10;
   localparam logic [1:0] ALU_ADD     = 2'b00;
   localparam logic [1:0] ALU_SUB     = 2'b01;
   localparam logic [1:0] ALU_RTYPE   = 2'b10;
   localparam logic [1:0] RES_ALUOUT  = 2'b00;
   localparam logic [1:0] RES_MDR     = 2'b01;
   localparam logic [1:0] RES_ALU     = 2'b10;

   state_e               state_q, state_d;
   logic [INSTRET_W-1:0] instret_q, instret_d;
   logic                 retire;

   logic       pc_write, ir_write, addr_src, mem_read, mem_write, reg_write;
   logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;

   // NOTE: every signal written here gets a default before the case; a path
   // that skipped an assignment would otherwise infer a latch.
   always_comb begin
      state_d    = state_q;
      retire     = 1'b0;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      addr_src   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_REGB;
      alu_op     = ALU_ADD;
      result_src = RES_ALUOUT;

      unique case (state_q)
         S_IDLE: state_d = S_FETCH;

         S_FETCH: begin
            // PC <= PC + 4 is written through the direct ALU result path in
            // the same cycle the fetched word lands in IR.
            mem_read   = 1'b1;
            addr_src   = 1'b0;
            alu_src_a  = SRC_A_PC;
            alu_src_b  = SRC_B_FOUR;
            alu_op     = ALU_ADD;
            result_src = RES_ALU;
            ir_write   = bus.mem_ready;
            pc_write   = bus.mem_ready;
            if (bus.mem_ready) state_d = S_DECODE;
         end

         S_DECODE: begin
            // Speculatively compute the branch target into ALUOut.
            alu_src_a = SRC_A_OLDPC;
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_ADD;
            if (bus.opcode == OP_LOAD || bus.opcode == OP_STORE)
               state_d = S_MEM_ADDR;
            else if (bus.opcode == OP_R)
               state_d = S_EXEC_R;
            else if (bus.opcode == OP_IMM && bus.funct3 == F3_ADDI)
               state_d = S_EXEC_I;
            else if (bus.opcode == OP_BRANCH && bus.funct3 == F3_BEQ)
               state_d = S_BRANCH;
            else
               state_d = S_TRAP;
         end

         S_MEM_ADDR: begin
            alu_src_a = SRC_A_REGA;
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_ADD;
            // Only lw and sw reach this state.
            state_d   = (bus.opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
         end

         S_MEM_READ: begin
            mem_read = 1'b1;
            addr_src = 1'b1;
            if (bus.mem_ready) state_d = S_MEM_WB;
         end

         S_MEM_WB: begin
            reg_write  = 1'b1;
            result_src = RES_MDR;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end

         S_MEM_WRITE: begin
            mem_write = 1'b1;
            addr_src  = 1'b1;
            if (bus.mem_ready) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end

         S_EXEC_R: begin
            alu_src_a = SRC_A_REGA;
            alu_src_b = SRC_B_REGB;
            alu_op    = ALU_RTYPE;
            state_d   = S_ALU_WB;
         end

         S_EXEC_I: begin
            alu_src_a = SRC_A_REGA;
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_ADD;
            state_d   = S_ALU_WB;
         end

         S_ALU_WB: begin
            reg_write  = 1'b1;
            result_src = RES_ALUOUT;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end

         S_BRANCH: begin
            // Compare regA - regB; a zero result loads the target held in
            // ALUOut since DECODE.
            alu_src_a  = SRC_A_REGA;
            alu_src_b  = SRC_B_REGB;
            alu_op     = ALU_SUB;
            result_src = RES_ALUOUT;
            pc_write   = bus.zero;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end

         S_TRAP: state_d = S_TRAP;

         default: state_d = S_IDLE;
      endcase

      instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   assign bus.pc_write   = pc_write;
   assign bus.ir_write   = ir_write;
   assign bus.addr_src   = addr_src;
   assign bus.mem_read   = mem_read;
   assign bus.mem_write  = mem_write;
   assign bus.alu_src_a  = alu_src_a;
   assign bus.alu_src_b  = alu_src_b;
   assign bus.alu_op     = alu_op;
   assign bus.result_src = result_src;
   assign bus.reg_write  = reg_write;
   // TRAP is absorbing until reset, which makes the flag sticky.
   assign bus.trap       = (state_q == S_TRAP);
   assign bus.state      = state_q;
   assign bus.instret    = instret_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main sequencing FSM for the multi-cycle RV32I core. It walks each instruction through fetch, decode, execute, memory and writeback. It drives `alu_op` into the ALU-control decoder, sets the ALU operand muxes, and waits on a shared instruction/data memory through a ready handshake. It also keeps a retired-instruction counter and latches a trap on unsupported opcodes.

## Interface
- `INSTRET_W`, default 32: width of the retired-instruction counter.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode` input 7: `IR[6:0]`; the IR is loaded at the end of FETCH and is stable from DECODE onward.
- `funct3` input 3: `IR[14:12]`.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory completes the current access this cycle.
- `pc_write` output 1: load PC.
- `ir_write` output 1: load IR and oldPC.
- `addr_src` output 1: memory address mux; 0 = PC, 1 = ALUOut.
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `alu_src_a` output 2: 00 = PC, 01 = oldPC, 10 = regA.
- `alu_src_b` output 2: 00 = regB, 01 = constant 4, 10 = immediate.
- `alu_op` output 2: to the ALU-control decoder; 00 = add, 01 = subtract/compare, 10 = R-type decode.
- `result_src` output 2: 00 = ALUOut, 01 = MDR, 10 = direct ALU result.
- `reg_write` output 1: register file write enable.
- `trap` output 1: sticky illegal-instruction flag.
- `state` output 4: current FSM state, for debug.
- `instret` output INSTRET_W: count of retired instructions.

## Operation
State encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXEC_R=7, EXEC_I=8, ALU_WB=9, BRANCH=10, TRAP=11.

Every output is 0 unless a state lists it.

- **IDLE**: all outputs 0. Always goes to FETCH next cycle.
- **FETCH**:
  - Drives `mem_read`=1, `addr_src`=0, `alu_src_a`=00, `alu_src_b`=01, `alu_op`=00, `result_src`=10.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- **DECODE**:
  - Drives `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00; this computes the branch target into ALUOut.
  - Next state by opcode:
    - 0000011 (lw) or 0100011 (sw): MEM_ADDR.
    - 0110011: EXEC_R.
    - 0010011 with `funct3`=000 (addi): EXEC_I.
    - 1100011 with `funct3`=000 (beq): BRANCH.
    - Anything else: TRAP.
- **MEM_ADDR**: drives `alu_src_a`=10, `alu_src_b`=10, `alu_op`=00. Goes to MEM_READ for lw, MEM_WRITE for sw.
- **MEM_READ**: drives `mem_read`=1, `addr_src`=1. Waits for `mem_ready`, then goes to MEM_WB.
- **MEM_WB**: drives `reg_write`=1, `result_src`=01. Goes to FETCH.
- **MEM_WRITE**: drives `mem_write`=1, `addr_src`=1. Waits for `mem_ready`, then goes to FETCH.
- **EXEC_R**: drives `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Goes to ALU_WB.
- **EXEC_I**: drives `alu_src_a`=10, `alu_src_b`=10, `alu_op`=00. Goes to ALU_WB.
- **ALU_WB**: drives `reg_write`=1, `result_src`=00. Goes to FETCH.
- **BRANCH**: drives `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, and `pc_write`=`zero`. Goes to FETCH.
- **TRAP**: `trap`=1, all strobes 0. Stays in TRAP until reset.

Counter and handshake rules:
- `instret` increments by 1 on each transition from MEM_WB, MEM_WRITE (with `mem_ready`=1), ALU_WB or BRANCH into FETCH.
- `instret` wraps modulo 2^INSTRET_W. An instruction that traps is not counted.
- A request (`mem_read` or `mem_write`) stays asserted with constant `addr_src` until a cycle with `mem_ready`=1. It drops in the following cycle.
- `mem_ready` is ignored in every state other than FETCH, MEM_READ and MEM_WRITE.

## Timing
- Reset (`rst_n`=0, asynchronous): `state`=IDLE, every output 0, `instret`=0, `trap`=0. This applies in any state, including mid-access.
- The first FETCH occurs 1 cycle after `rst_n` rises.
- With zero-wait memory (`mem_ready` held at 1), cycles per instruction:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
- Each wait cycle in FETCH, MEM_READ or MEM_WRITE adds exactly 1 cycle.
- Outputs are Moore-decoded from `state`. The exceptions are `ir_write`/`pc_write` in FETCH (qualified by `mem_ready`) and `pc_write` in BRANCH (qualified by `zero`). All of these are combinational from registered state and current inputs.

## Test plan
- **Reset and idle**: hold `rst_n` low, release → `state`=0, all outputs 0, next cycle `state`=1 with `mem_read`=1.
- **R-type**: opcode 0110011, `mem_ready`=1 → states 1,2,7,9,1.
  - `alu_op`=10 in EXEC_R.
  - `reg_write` pulses 1 cycle.
  - `instret` goes 0→1.
- **lw with memory wait**: opcode 0000011, `mem_ready` low for 2 cycles in MEM_READ → 7 cycles total.
  - `mem_read` and `addr_src`=1 held steady throughout the wait.
  - `result_src`=01 in MEM_WB.
- **beq taken vs. not taken**: opcode 1100011, `funct3`=000.
  - `zero`=1 → `pc_write`=1 in BRANCH.
  - `zero`=0 → `pc_write`=0.
  - Both cases take 3 cycles and increment `instret`.
- **Illegal opcode**: 1110011, or opcode 0010011 with `funct3`=001 → TRAP.
  - `trap`=1 sticky, no strobes, `instret` unchanged.
  - Asserting `rst_n`=0 clears it.
- **Asynchronous reset mid-access**: assert `rst_n`=0 during MEM_WRITE with `mem_ready`=0 → `mem_write` drops in the same cycle, `state`=0 immediately, `instret`=0.
